// File: rtl/stats_pkg.sv
// Shared constants and helpers for the statistics stream arbiter.
// Holds the default widths and flush period plus a ceil-log2 helper for parameter math.
package stats_pkg;

    localparam int STAT_INC_WIDTH_DEF = 24;
    localparam int STAT_ID_WIDTH_DEF  = 5;
    localparam int UPDATE_PERIOD_DEF  = 1024;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/stats_rr_arb.sv
// Round-robin grant selection over a request vector.
// The search begins at the index after the last advanced grant; after reset it begins at 0.
module stats_rr_arb
    import stats_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int PORT_WIDTH = clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PORTS-1:0]      req_i,
    input  logic                  advance_i,
    output logic [PORT_WIDTH-1:0] grant_o,
    output logic                  grant_valid_o
);

    logic [PORT_WIDTH-1:0] start_q;
    logic [PORT_WIDTH-1:0] start_d;
    logic [PORT_WIDTH:0]   sum;
    logic [PORT_WIDTH-1:0] idx;

    // Walk from the farthest candidate back to start_q so the nearest requester wins.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        sum           = '0;
        idx           = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, start_q} + (PORT_WIDTH + 1)'(k);
            if (sum >= (PORT_WIDTH + 1)'(PORTS)) begin
                sum = sum - (PORT_WIDTH + 1)'(PORTS);
            end
            idx = sum[PORT_WIDTH-1:0];
            if (req_i[idx]) begin
                grant_o       = idx;
                grant_valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        start_d = start_q;
        if (advance_i) begin
            if (grant_o == PORT_WIDTH'(PORTS - 1)) begin
                start_d = '0;
            end else begin
                start_d = grant_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end

endmodule

// File: rtl/stats_stream_arb.sv
// Merges per-source statistics increments into one stream and schedules periodic flush requests.
// Optional build macro STATS_ARB_ZERO_DROP_EN: accept zero increments and discard them.
module stats_stream_arb
    import stats_pkg::*;
#(
    parameter int  PORTS          = 4,
    parameter int  STAT_INC_WIDTH = STAT_INC_WIDTH_DEF,
    parameter int  STAT_ID_WIDTH  = STAT_ID_WIDTH_DEF,
    parameter int  UPDATE_PERIOD  = UPDATE_PERIOD_DEF,
    localparam int PORT_WIDTH     = clog2(PORTS),
    localparam int OUT_ID_WIDTH   = STAT_ID_WIDTH + PORT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PORTS*STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
    input  logic [PORTS*STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
    input  logic [PORTS-1:0]                  s_axis_stat_tvalid,
    output logic [PORTS-1:0]                  s_axis_stat_tready,
    output logic [STAT_INC_WIDTH-1:0]         m_axis_stat_tdata,
    output logic [OUT_ID_WIDTH-1:0]           m_axis_stat_tid,
    output logic                              m_axis_stat_tvalid,
    input  logic                              m_axis_stat_tready,
    output logic [PORTS-1:0]                  update_out,
    input  logic                              update_all
);

    localparam int STEP      = UPDATE_PERIOD / PORTS;
    localparam int CNT_WIDTH = clog2(UPDATE_PERIOD);

    logic [PORT_WIDTH-1:0]     grant;
    logic                      grant_valid;
    logic                      accept;
    logic                      drop;
    logic [STAT_INC_WIDTH-1:0] sel_data;
    logic [STAT_ID_WIDTH-1:0]  sel_id;

    logic                      out_valid_q;
    logic [STAT_INC_WIDTH-1:0] out_data_q;
    logic [OUT_ID_WIDTH-1:0]   out_id_q;

    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [CNT_WIDTH-1:0]      cnt_d;
    logic [PORTS-1:0]          update_q;
    logic [PORTS-1:0]          update_d;

    stats_rr_arb #(
        .PORTS      (PORTS),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_rr_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (s_axis_stat_tvalid),
        .advance_i     (accept),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant == PORT_WIDTH'(i)) begin
                sel_data = s_axis_stat_tdata[i*STAT_INC_WIDTH +: STAT_INC_WIDTH];
                sel_id   = s_axis_stat_tid[i*STAT_ID_WIDTH +: STAT_ID_WIDTH];
            end
        end
    end

    // Handshake: a beat moves when valid and ready are both high in a cycle. Ready goes only to
    // the granted port, only when the output register is free or draining, and is held low in reset.
    assign accept = rst_n && grant_valid && (!out_valid_q || m_axis_stat_tready);

    always_comb begin
        s_axis_stat_tready = '0;
        for (int i = 0; i < PORTS; i++) begin
            s_axis_stat_tready[i] = accept && (grant == PORT_WIDTH'(i));
        end
    end

`ifdef STATS_ARB_ZERO_DROP_EN
    assign drop = (sel_data == '0);
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else if (accept && !drop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_id_q    <= {grant, sel_id};
        end else if (m_axis_stat_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign m_axis_stat_tvalid = out_valid_q;
    assign m_axis_stat_tdata  = out_data_q;
    assign m_axis_stat_tid    = out_id_q;

    // Pulses decode the next counter value, so a flush lands in the slot a scheduled pulse would use.
    always_comb begin
        if (update_all) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_WIDTH'(UPDATE_PERIOD - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        update_d = '0;
        for (int i = 0; i < PORTS; i++) begin
            update_d[i] = update_all || (cnt_d == CNT_WIDTH'(i * STEP));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            update_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            update_q <= update_d;
        end
    end

    assign update_out = update_q;

endmodule
